// File: rtl/led_switch_mode_ctrl.sv
`default_nettype none
// =============================================================================
// led_switch_mode_ctrl : button-stepped display mode with PASS/INVERT/CHASE/BLINK
// Rev 1.0
// =============================================================================
module led_switch_mode_ctrl #(
  parameter int NUM_MODES = 4,
  parameter int SW_WIDTH  = 8,
  parameter int LED_WIDTH = 8,
  parameter int WRAP      = 1,
  parameter int TICK_DIV  = 25000000,
  localparam int MODE_W   = ($clog2(NUM_MODES) > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 button_center_db,
  input  logic                 button_up_db,
  input  logic                 button_down_db,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic [MODE_W-1:0]    mode,
  output logic                 mode_changed,
  output logic [LED_WIDTH-1:0] leds
);

  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  logic                 prev_center;
  logic                 prev_up;
  logic                 prev_down;
  logic                 inc;
  logic                 dec;
  logic [MODE_W-1:0]    mode_next;
  logic [1:0]           mode_cur;
  logic [1:0]           mode_nxt2;
  logic                 entering;
  logic [PS_W-1:0]      ps_cnt;
  logic                 tick;
  logic [LED_WIDTH-1:0] sw_ext;
  logic [LED_WIDTH-1:0] chase;
  logic                 blink;
  logic [LED_WIDTH-1:0] leds_next;

  assign inc = (button_center_db & ~prev_center) | (button_up_db & ~prev_up);
  assign dec = button_down_db & ~prev_down;

  // 2-bit views keep the mode decode uniform when only one mode bit exists
  assign mode_cur  = 2'(mode);
  assign mode_nxt2 = 2'(mode_next);
  assign entering  = (mode_next != mode);

  // State register: mode, change pulse and button history
  always_ff @(posedge clk) begin
    if (rst) begin
      mode         <= '0;
      mode_changed <= 1'b0;
      prev_center  <= 1'b1;
      prev_up      <= 1'b1;
      prev_down    <= 1'b1;
    end else begin
      mode         <= mode_next;
      mode_changed <= entering;
      prev_center  <= button_center_db;
      prev_up      <= button_up_db;
      prev_down    <= button_down_db;
    end
  end

  // Next-state: simultaneous inc and dec cancel
  always_comb begin
    mode_next = mode;
    if (inc && !dec) begin
      if (mode != LAST_MODE)
        mode_next = mode + 1'b1;
      else if (WRAP != 0)
        mode_next = '0;
    end else if (dec && !inc) begin
      if (mode != '0)
        mode_next = mode - 1'b1;
      else if (WRAP != 0)
        mode_next = LAST_MODE;
    end
  end

  assign tick = (ps_cnt == PS_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick)
      ps_cnt <= '0;
    else
      ps_cnt <= ps_cnt + 1'b1;
  end

  generate
    if (SW_WIDTH < LED_WIDTH) begin : g_sw_zext
      assign sw_ext = {{(LED_WIDTH - SW_WIDTH){1'b0}}, switches};
    end else begin : g_sw_trunc
      assign sw_ext = switches[LED_WIDTH-1:0];
    end

    if (NUM_MODES > 2) begin : g_chase
      logic [LED_WIDTH-1:0] chase_q;
      always_ff @(posedge clk) begin
        if (rst)
          chase_q <= LED_WIDTH'(1);
        else if (entering && mode_nxt2 == MODE_CHASE)
          chase_q <= LED_WIDTH'(1);
        else if (tick)
          chase_q <= {chase_q[LED_WIDTH-2:0], chase_q[LED_WIDTH-1]};
      end
      assign chase = chase_q;
    end else begin : g_no_chase
      assign chase = '0;
    end

    if (NUM_MODES > 3) begin : g_blink
      logic blink_q;
      always_ff @(posedge clk) begin
        if (rst)
          blink_q <= 1'b1;
        else if (entering && mode_nxt2 == MODE_BLINK)
          blink_q <= 1'b1;
        else if (tick)
          blink_q <= ~blink_q;
      end
      assign blink = blink_q;
    end else begin : g_no_blink
      assign blink = 1'b0;
    end
  endgenerate

  // Output decode from the current mode; leds therefore lag mode by one clk
  always_comb begin
    leds_next = '0;
    case (mode_cur)
      MODE_PASS:   leds_next = sw_ext;
      MODE_INVERT: leds_next = ~sw_ext;
      MODE_CHASE:  leds_next = chase;
      MODE_BLINK:  leds_next = blink ? sw_ext : '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      leds <= '0;
    else
      leds <= leds_next;
  end

endmodule
`default_nettype wire

// File: tb/tb_led_switch_mode_ctrl.sv
`default_nettype none
// =============================================================================
// tb_led_switch_mode_ctrl : directed checks on wrap, saturate and narrow-switch builds
// Rev 1.0
// =============================================================================
module tb_led_switch_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_c, a_u, a_d;
  logic       b_c, b_u, b_d;
  logic       c_c, c_u, c_d;
  logic [7:0] a_sw, b_sw;
  logic [3:0] c_sw;
  logic [1:0] a_mode, b_mode, c_mode;
  logic       a_chg, b_chg, c_chg;
  logic [7:0] a_leds, b_leds, c_leds;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  always #5 clk = ~clk;

  led_switch_mode_ctrl #(.NUM_MODES(4), .SW_WIDTH(8), .LED_WIDTH(8), .WRAP(1), .TICK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .button_center_db(a_c), .button_up_db(a_u), .button_down_db(a_d),
    .switches(a_sw), .mode(a_mode), .mode_changed(a_chg), .leds(a_leds));

  led_switch_mode_ctrl #(.NUM_MODES(4), .SW_WIDTH(8), .LED_WIDTH(8), .WRAP(0), .TICK_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .button_center_db(b_c), .button_up_db(b_u), .button_down_db(b_d),
    .switches(b_sw), .mode(b_mode), .mode_changed(b_chg), .leds(b_leds));

  led_switch_mode_ctrl #(.NUM_MODES(4), .SW_WIDTH(4), .LED_WIDTH(8), .WRAP(1), .TICK_DIV(4)) dut_c (
    .clk(clk), .rst(rst), .button_center_db(c_c), .button_up_db(c_u), .button_down_db(c_d),
    .switches(c_sw), .mode(c_mode), .mode_changed(c_chg), .leds(c_leds));

  always @(posedge clk) begin
    if (a_chg === 1'b1) pulses_a++;
    if (b_chg === 1'b1) pulses_b++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      edge_no++;
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_c = 0; a_u = 0; a_d = 0;
    b_c = 0; b_u = 0; b_d = 0;
    c_c = 0; c_u = 0; c_d = 0;
    a_sw = 8'h3C; b_sw = 8'h00; c_sw = 4'hF;

    // Reset state
    step(2);
    check("rst_a_mode", 32'(a_mode), 0);
    check("rst_a_chg",  32'(a_chg),  0);
    check("rst_a_leds", 32'(a_leds), 0);
    check("rst_b_mode", 32'(b_mode), 0);
    check("rst_c_leds", 32'(c_leds), 0);

    rst = 1'b0;
    edge_no = 0;
    step(1);
    check("pass_a_leds", 32'(a_leds), 32'h3C);
    check("pass_c_zext", 32'(c_leds), 32'h0F);

    // Center press, then held for 100 cycles: one increment only
    a_c = 1'b1;
    step(1);
    check("inc1_mode", 32'(a_mode), 1);
    check("inc1_chg",  32'(a_chg),  1);
    check("inc1_leds_lag", 32'(a_leds), 32'h3C);
    step(1);
    check("inc1_chg_drop", 32'(a_chg), 0);
    check("invert_leds", 32'(a_leds), 32'hC3);
    step(98);
    check("held_mode", 32'(a_mode), 1);
    a_c = 1'b0;
    step(1);

    // CHASE: enter just after a prescaler tick so tick edges fall at E+3, E+7, ...
    while (edge_no % 4 != 0) step(1);
    a_c = 1'b1;
    step(1);
    check("chase_mode", 32'(a_mode), 2);
    check("chase_chg",  32'(a_chg),  1);
    a_c = 1'b0;
    step(1);
    check("chase_e1", 32'(a_leds), 32'h01);
    step(2);
    check("chase_e3", 32'(a_leds), 32'h01);
    step(1);
    check("chase_e4", 32'(a_leds), 32'h02);
    for (int i = 2; i <= 8; i++) begin
      step(4);
      check("chase_step", 32'(a_leds), 32'(1) << (i % 8));
    end

    // BLINK with switches 0xA5
    a_sw = 8'hA5;
    while (edge_no % 4 != 0) step(1);
    a_c = 1'b1;
    step(1);
    check("blink_mode", 32'(a_mode), 3);
    a_c = 1'b0;
    step(1);
    check("blink_f1", 32'(a_leds), 32'hA5);
    step(2);
    check("blink_f3", 32'(a_leds), 32'hA5);
    step(1);
    check("blink_f4", 32'(a_leds), 32'h00);
    for (int i = 2; i <= 4; i++) begin
      step(4);
      check("blink_step", 32'(a_leds), (i % 2 == 0) ? 32'hA5 : 32'h00);
    end

    // Wrap 3 -> 0
    a_c = 1'b1;
    step(1);
    check("wrap_mode", 32'(a_mode), 0);
    check("wrap_chg",  32'(a_chg),  1);
    a_c = 1'b0;
    step(1);
    check("wrap_chg_drop", 32'(a_chg), 0);
    check("wrap_pass_leds", 32'(a_leds), 32'hA5);
    check("pulses_a_4", 32'(pulses_a), 4);

    // Up and down rising together at mode 1 cancel
    a_u = 1'b1;
    step(1);
    check("up_mode", 32'(a_mode), 1);
    a_u = 1'b0;
    step(1);
    a_u = 1'b1; a_d = 1'b1;
    step(1);
    check("cancel_mode", 32'(a_mode), 1);
    check("cancel_chg",  32'(a_chg),  0);
    a_u = 1'b0; a_d = 1'b0;
    step(1);
    check("pulses_a_5", 32'(pulses_a), 5);

    // Saturating build: down at 0 holds, up saturates at 3
    b_d = 1'b1;
    step(1);
    check("sat_down_mode", 32'(b_mode), 0);
    check("sat_down_chg",  32'(b_chg),  0);
    b_d = 1'b0;
    step(1);
    for (int k = 1; k <= 3; k++) begin
      b_u = 1'b1;
      step(1);
      check("sat_up_mode", 32'(b_mode), 32'(k));
      check("sat_up_chg",  32'(b_chg),  1);
      b_u = 1'b0;
      step(1);
    end
    b_u = 1'b1;
    step(1);
    check("sat_top_mode", 32'(b_mode), 3);
    check("sat_top_chg",  32'(b_chg),  0);
    b_u = 1'b0;
    step(1);
    check("pulses_b_3", 32'(pulses_b), 3);

    // Narrow switches inverted into 8 LEDs
    c_c = 1'b1;
    step(1);
    check("c_mode1", 32'(c_mode), 1);
    c_c = 1'b0;
    step(1);
    check("c_invert", 32'(c_leds), 32'hF0);

    // Reset coinciding with a center rise at mode 2; c held through reset
    a_c = 1'b1;
    step(1);
    check("pre_rst_mode", 32'(a_mode), 2);
    a_c = 1'b0;
    step(1);
    a_c = 1'b1; c_c = 1'b1; rst = 1'b1;
    step(1);
    check("rst_ovr_mode", 32'(a_mode), 0);
    check("rst_ovr_leds", 32'(a_leds), 0);
    check("rst_ovr_chg",  32'(a_chg),  0);
    rst = 1'b0;
    step(1);
    check("post_rst_mode", 32'(a_mode), 0);
    check("post_rst_chg",  32'(a_chg),  0);
    check("post_rst_leds", 32'(a_leds), 32'hA5);
    step(3);
    check("held_rst_a_mode", 32'(a_mode), 0);
    check("held_rst_c_mode", 32'(c_mode), 0);
    check("held_rst_c_leds", 32'(c_leds), 32'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_switch_mode_ctrl.md
LED_SWITCH_MODE_CTRL -- requirements
Module: led_switch_mode_ctrl

Interface
REQ-001 SHALL have parameter NUM_MODES, default 4, number of selectable display modes, legal range 2..4.
REQ-002 SHALL have parameter SW_WIDTH, default 8, switch input width, legal range 1..16.
REQ-003 SHALL have parameter LED_WIDTH, default 8, LED output width, legal range 2..16.
REQ-004 SHALL have parameter WRAP, default 1; 1 = mode index wraps, 0 = mode index saturates.
REQ-005 SHALL have parameter TICK_DIV, default 25000000, clk cycles per animation tick, legal range 2..2^26.
REQ-006 SHALL have port clk, input, 1, system clock; all state on posedge clk.
REQ-007 SHALL have port rst, input, 1; reset rst, synchronous, active-high.
REQ-008 SHALL have port button_center_db, input, 1, debounced level, next-mode request.
REQ-009 SHALL have port button_up_db, input, 1, debounced level, next-mode request.
REQ-010 SHALL have port button_down_db, input, 1, debounced level, previous-mode request.
REQ-011 SHALL have port switches, input, SW_WIDTH, raw switch levels.
REQ-012 SHALL have port mode, output, MODE_W = max(1, clog2(NUM_MODES)), current mode index, registered.
REQ-013 SHALL have port mode_changed, output, 1, one-cycle pulse, registered.
REQ-014 SHALL have port leds, output, LED_WIDTH, LED drive, registered.

Function
REQ-015 Buttons SHALL NOT be used as clocks; each button SHALL be sampled into a prev register every clk, rise = level & ~prev.
REQ-016 inc = center_rise | up_rise; dec = down_rise; inc and dec in the same cycle SHALL cancel (no mode change, no pulse).
REQ-017 On inc alone: mode < NUM_MODES-1 -> mode+1; mode = NUM_MODES-1 -> 0 if WRAP=1, else hold.
REQ-018 On dec alone: mode > 0 -> mode-1; mode = 0 -> NUM_MODES-1 if WRAP=1, else hold.
REQ-019 mode SHALL update at the clk edge where the rise is sampled; mode_changed SHALL be 1 in exactly the cycle the new mode value first appears, and 0 on a saturated hold.
REQ-020 A button held high SHALL produce only one request; a new request requires a low sample first.
REQ-021 Prescaler SHALL count 0..TICK_DIV-1 free-running, asserting internal tick for one cycle at TICK_DIV-1, then returning to 0.
REQ-022 sw_ext = switches zero-extended to LED_WIDTH if SW_WIDTH < LED_WIDTH, else switches[LED_WIDTH-1:0].
REQ-023 Mode 0 (PASS): leds <= sw_ext every cycle.
REQ-024 Mode 1 (INVERT): leds <= ~sw_ext every cycle.
REQ-025 Mode 2 (CHASE): one-hot chase register SHALL load 1 (bit 0) on the cycle mode becomes 2, rotate left by one on each tick (MSB -> bit 0); leds <= chase register.
REQ-026 Mode 3 (BLINK): blink phase SHALL be set to 1 on the cycle mode becomes 3, toggle on each tick; leds <= sw_ext when phase=1, else all zeros.
REQ-027 leds SHALL lag mode and switches by one clk (registered from current mode/switches).
REQ-028 Modes >= NUM_MODES SHALL be unreachable; behaviours for unconfigured modes SHALL NOT be synthesised beyond dead logic.
REQ-029 Prescaler SHALL NOT restart on mode change; CHASE/BLINK first tick follows the free-running prescaler.

Reset
REQ-030 While rst=1 at posedge clk: mode=0, mode_changed=0, leds=0, prescaler=0, chase register=1, blink phase=1, all button prev registers=1.
REQ-031 prev=1 after reset SHALL suppress a request from a button already held during reset.
REQ-032 rst mid-operation SHALL override any same-cycle inc/dec; first leds value after rst release is PASS of switches one cycle later.

Verification
REQ-033 NUM_MODES=4, WRAP=1: four center presses from reset -> mode 1,2,3,0, one mode_changed pulse each, 3->0 wrap observed.
REQ-034 WRAP=0: down press at mode 0 -> mode stays 0, mode_changed stays 0; three up presses then up -> mode 3, holds 3, no fourth pulse.
REQ-035 up and down rise in same cycle at mode 1 -> mode stays 1, no pulse; center held 100 cycles -> exactly one increment.
REQ-036 LED_WIDTH=8, TICK_DIV=4, mode 2 -> leds 0x01, 0x02, ... 0x80, 0x01 one step per 4 cycles; mode 3 with switches=0xA5 -> leds alternate 0xA5/0x00 every 4 cycles.
REQ-037 SW_WIDTH=4, LED_WIDTH=8, switches=0xF, mode 1 -> leds=0xF0; button held through rst release -> no mode change.
REQ-038 rst asserted in the cycle of a center rise at mode 2 -> next cycle mode=0, leds=0, mode_changed=0.
